// File: rtl/food_spawner.sv
// ---------------------------------------------------------------------------
// food_spawner
//
// Picks a free grid cell for the next piece of food. A Galois LFSR free-runs
// every cycle; on a request the FSM draws candidates from it, asks the outside
// world whether the candidate cell is occupied, and after MAX_TRIES failed
// draws falls back to a raster scan of the whole legal grid. The result is
// presented one cycle after the FSM has already returned to IDLE, so a new
// request can be accepted while valid/fail is high.
//
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   req                - spawn request (ignored while busy)
//   seed_load, seed_in - reseed the LFSR (zero seed loads 1)
//   probe_x, probe_y   - cell currently being asked about
//   occupied           - combinational answer for the probe (1 = snake)
//   x_out, y_out       - last food position
//   valid              - one-cycle pulse when x_out/y_out are updated
//   fail               - one-cycle pulse when no free cell exists
//   busy               - high while a request is being processed
// ---------------------------------------------------------------------------
module food_spawner #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                COORD_W   = 3,
  parameter int                GRID_W    = 8,
  parameter int                GRID_H    = 8,
  parameter int                MAX_TRIES = 15,
  parameter int                RST_X     = 3,
  parameter int                RST_Y     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  output logic [COORD_W-1:0] probe_x,
  output logic [COORD_W-1:0] probe_y,
  input  logic               occupied,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               valid,
  output logic               fail,
  output logic               busy
);

  localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0]  SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] RST_XC   = COORD_W'(RST_X);
  localparam logic [COORD_W-1:0] RST_YC   = COORD_W'(RST_Y);

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, SCAN} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [COORD_W-1:0] probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic               valid_q, valid_d, fail_q, fail_d, busy_q, busy_d;
  // hit/miss remember the outcome decided on the cycle the FSM went IDLE;
  // the outputs are published from them one cycle later.
  logic               hit_q, hit_d, miss_q, miss_d;

  logic [COORD_W-1:0] cand_x, cand_y;
  logic               cand_ok, last_try;

  assign cand_x   = lfsr_q[COORD_W-1:0];
  assign cand_y   = lfsr_q[2*COORD_W-1:COORD_W];
  assign cand_ok  = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);
  // True when the failure being counted now is the last one allowed.
  assign last_try = (int'(tries_q) + 1 >= MAX_TRIES);

  // Next-state logic: LFSR stepping, the spawn FSM and output publication.
  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? LFSR_W'(1) : seed_in;
    end else begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (!cand_ok) begin
          tries_d = tries_q + TRY_W'(1);
          if (last_try) begin
            state_d   = SCAN;
            probe_x_d = '0;
            probe_y_d = '0;
          end
        end else begin
          probe_x_d = cand_x;
          probe_y_d = cand_y;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (!occupied) begin
          hit_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
          if (last_try) begin
            state_d   = SCAN;
            probe_x_d = '0;
            probe_y_d = '0;
          end else begin
            state_d = DRAW;
          end
        end
      end
      SCAN: begin
        if (!occupied) begin
          hit_d   = 1'b1;
          state_d = IDLE;
        end else if (probe_x_q == LAST_X && probe_y_q == LAST_Y) begin
          miss_d  = 1'b1;
          state_d = IDLE;
        end else if (probe_x_q == LAST_X) begin
          probe_x_d = '0;
          probe_y_d = probe_y_q + COORD_W'(1);
        end else begin
          probe_x_d = probe_x_q + COORD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = hit_q;
    fail_d  = miss_q;
    // The probe is untouched while IDLE, so it still holds the winning cell.
    x_out_d = hit_q ? probe_x_q : x_out_q;
    y_out_d = hit_q ? probe_y_q : y_out_q;
  end

  // State registers; reset aborts any request without a result pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      tries_q   <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
      x_out_q   <= RST_XC;
      y_out_q   <= RST_YC;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      tries_q   <= tries_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      valid_q   <= valid_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign probe_x = probe_x_q;
  assign probe_y = probe_y_q;
  assign x_out   = x_out_q;
  assign y_out   = y_out_q;
  assign valid   = valid_q;
  assign fail    = fail_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_food_spawner.sv
// ---------------------------------------------------------------------------
// tb_food_spawner
//
// Two instances: index 0 uses the default 8x8 grid, index 1 a 5x6 grid.
// The occupancy answer comes from a per-instance 64-bit map indexed by
// {probe_y, probe_x}. A reference model derives the expected cell, outcome
// and latency of each request from the LFSR value and the occupancy map.
// ---------------------------------------------------------------------------
module tb_food_spawner;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] TAPS      = 16'hB400;
  localparam int          MAX_TRIES = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req       [2];
  logic        seed_load [2];
  logic [15:0] seed_in   [2];
  logic [2:0]  probe_x   [2];
  logic [2:0]  probe_y   [2];
  logic        occupied  [2];
  logic [2:0]  x_out     [2];
  logic [2:0]  y_out     [2];
  logic        valid     [2];
  logic        fail      [2];
  logic        busy      [2];
  logic [63:0] occ_map   [2];
  logic [15:0] mlfsr     [2];
  int          exp_x     [2];
  int          exp_y     [2];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] occ;
    bit          ok;
    int          x;
    int          y;
  } vec_t;

  always #5 clk = ~clk;

  food_spawner dut (
    .clk(clk), .reset(reset), .req(req[0]), .seed_load(seed_load[0]),
    .seed_in(seed_in[0]), .probe_x(probe_x[0]), .probe_y(probe_y[0]),
    .occupied(occupied[0]), .x_out(x_out[0]), .y_out(y_out[0]),
    .valid(valid[0]), .fail(fail[0]), .busy(busy[0])
  );

  food_spawner #(.GRID_W(5), .GRID_H(6)) dut_small (
    .clk(clk), .reset(reset), .req(req[1]), .seed_load(seed_load[1]),
    .seed_in(seed_in[1]), .probe_x(probe_x[1]), .probe_y(probe_y[1]),
    .occupied(occupied[1]), .x_out(x_out[1]), .y_out(y_out[1]),
    .valid(valid[1]), .fail(fail[1]), .busy(busy[1])
  );

  // The snake board answers the probe combinationally.
  assign occupied[0] = occ_map[0][{probe_y[0], probe_x[0]}];
  assign occupied[1] = occ_map[1][{probe_y[1], probe_x[1]}];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  function automatic int gw(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic int gh(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  // Reference LFSR for each instance, value held after every edge.
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset)             mlfsr[d] <= SEED;
      else if (seed_load[d]) mlfsr[d] <= (seed_in[d] == 16'h0) ? 16'h0001 : seed_in[d];
      else                   mlfsr[d] <= lfsr_next(mlfsr[d]);
    end
  end

  // Expected outcome of one request. l0 is the LFSR value in the cycle the
  // request is sampled; lat counts edges from the accepting edge until the
  // edge after which valid/fail is high. A draw in cycle c uses the LFSR
  // stepped c times; an in-range draw spends a second cycle on the check.
  function automatic void spawnModel(input logic [15:0] l0, input logic [63:0] occ,
                                     input int w, input int h, output bit ok,
                                     output int ex, output int ey, output int lat);
    logic [15:0] l;
    int c, tries, x, y, s;
    bit to_scan;
    l = lfsr_next(l0); c = 1; tries = 0; to_scan = 0; s = 0;
    ok = 0; ex = 0; ey = 0; lat = 0;
    while (!to_scan) begin
      x = int'(l[2:0]);
      y = int'(l[5:3]);
      if (x >= w || y >= h) begin
        tries++;
        if (tries == MAX_TRIES) begin to_scan = 1; s = c + 1; end
        else begin c++; l = lfsr_next(l); end
      end else if (!occ[y*8+x]) begin
        ok = 1; ex = x; ey = y; lat = c + 2;
        return;
      end else begin
        tries++;
        if (tries == MAX_TRIES) begin to_scan = 1; s = c + 2; end
        else begin c += 2; l = lfsr_next(lfsr_next(l)); end
      end
    end
    for (int k = 0; k < w*h; k++) begin
      x = k % w;
      y = k / w;
      if (!occ[y*8+x]) begin
        ok = 1; ex = x; ey = y; lat = s + k + 1;
        return;
      end
    end
    lat = s + w*h;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request, called at a negedge; returns at the negedge where the
  // result pulse is visible so a follow-up request can start right there.
  task automatic applyStimulus(input int d, input logic [63:0] occ, input int budget);
    logic [15:0] l0;
    bit m_ok;
    int mx, my, mlat, k;
    string p;
    p = $sformatf("d%0d_", d);
    occ_map[d] = occ;
    l0 = mlfsr[d];
    spawnModel(l0, occ, gw(d), gh(d), m_ok, mx, my, mlat);
    req[d] = 1'b1;
    @(negedge clk);
    req[d] = 1'b0;
    checkOutput({p, "busy_after_accept"}, 32'(busy[d]), 32'd1);
    k = 0;
    while (!(valid[d] || fail[d]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({p, "done_pulse"}, 32'(valid[d] | fail[d]), 32'd1);
    checkOutput({p, "valid_vs_fail"}, 32'(valid[d]), 32'(m_ok));
    checkOutput({p, "no_overlap"}, 32'(valid[d] & fail[d]), 32'd0);
    checkOutput({p, "latency"}, 32'(k), 32'(mlat));
    if (m_ok) begin
      exp_x[d] = mx;
      exp_y[d] = my;
    end
    checkOutput({p, "x_out"}, 32'(x_out[d]), 32'(exp_x[d]));
    checkOutput({p, "y_out"}, 32'(y_out[d]), 32'(exp_y[d]));
    checkOutput({p, "busy_at_done"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    vec_t table_v[$];
    vec_t v;
    int busy_cnt, n_valid, n_fail, k;
    logic [63:0] occ;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; seed_load[d] = 1'b0; seed_in[d] = 16'h0; occ_map[d] = 64'h0;
      exp_x[d] = 3; exp_y[d] = 1;
    end

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_x_out", 32'(x_out[0]), 32'd3);
    checkOutput("rst_y_out", 32'(y_out[0]), 32'd1);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_valid", 32'(valid[0]), 32'd0);
    checkOutput("rst_fail", 32'(fail[0]), 32'd0);
    checkOutput("rst_probe", 32'({probe_y[0], probe_x[0]}), 32'd0);
    checkOutput("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("lfsr_first_step", 32'(dut.lfsr_q), 32'hE270);
    checkOutput("lfsr_track_small", 32'(dut_small.lfsr_q), 32'(mlfsr[1]));

    // Empty board: minimum latency, cell straight from the LFSR.
    applyStimulus(0, 64'h0, 20);

    // Table of boards whose answer is fixed regardless of the LFSR.
    table_v.push_back('{~(64'h1 << (2*8+5)), 1'b1, 5, 2});
    table_v.push_back('{~(64'h1 << 0),       1'b1, 0, 0});
    table_v.push_back('{~(64'h1 << 63),      1'b1, 7, 7});
    table_v.push_back('{~(64'h1 << (6*8+3)), 1'b1, 3, 6});
    table_v.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0});
    for (int i = 0; i < table_v.size(); i++) begin
      v = table_v[i];
      if (!v.ok) begin v.x = exp_x[0]; v.y = exp_y[0]; end
      applyStimulus(0, v.occ, 200);
      checkOutput($sformatf("table%0d_x", i), 32'(x_out[0]), 32'(v.x));
      checkOutput($sformatf("table%0d_y", i), 32'(y_out[0]), 32'(v.y));
      @(negedge clk);
    end

    // Full board: every draw and every scan cycle show up as busy time;
    // a req pulsed mid-operation must not be queued.
    occ_map[0] = '1;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    busy_cnt = busy[0] ? 1 : 0;
    n_valid = 0; n_fail = 0; k = 0;
    while (!(valid[0] || fail[0]) && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 5) req[0] = 1'b1;
      if (k == 8) req[0] = 1'b0;
      if (busy[0]) busy_cnt++;
    end
    checkOutput("full_busy_cycles", 32'(busy_cnt), 32'(2*MAX_TRIES + 64));
    checkOutput("full_fail", 32'(fail[0]), 32'd1);
    checkOutput("full_no_valid", 32'(valid[0]), 32'd0);
    checkOutput("full_x_kept", 32'(x_out[0]), 32'(exp_x[0]));
    checkOutput("full_y_kept", 32'(y_out[0]), 32'(exp_y[0]));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid[0]) n_valid++;
      if (fail[0]) n_fail++;
      if (busy[0]) n_fail++;
    end
    checkOutput("full_no_queued_req", 32'(n_valid + n_fail), 32'd0);

    // Random boards and occasional reseeds against the model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed_load[0] = 1'b1;
        seed_in[0] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
        @(negedge clk);
        seed_load[0] = 1'b0;
        checkOutput("seed_track", 32'(dut.lfsr_q), 32'(mlfsr[0]));
      end
      case ($urandom_range(0, 3))
        0:       occ = {32'($urandom), 32'($urandom)};
        1:       occ = {32'($urandom), 32'($urandom)} | {32'($urandom), 32'($urandom)};
        2:       occ = {32'($urandom), 32'($urandom)} | {32'($urandom), 32'($urandom)}
                     | {32'($urandom), 32'($urandom)} | {32'($urandom), 32'($urandom)};
        default: occ = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      endcase
      applyStimulus(0, occ, 200);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset while scanning a full board aborts without a pulse.
    occ_map[0] = '1;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("scan_busy_before_reset", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_x_out", 32'(x_out[0]), 32'd3);
    checkOutput("arst_y_out", 32'(y_out[0]), 32'd1);
    checkOutput("arst_busy", 32'(busy[0]), 32'd0);
    checkOutput("arst_probe", 32'({probe_y[0], probe_x[0]}), 32'd0);
    checkOutput("arst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    exp_x[0] = 3; exp_y[0] = 1; exp_x[1] = 3; exp_y[1] = 1;
    @(negedge clk);
    reset = 1'b0;
    n_valid = 0; n_fail = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid[0]) n_valid++;
      if (fail[0] || busy[0]) n_fail++;
    end
    checkOutput("arst_no_pulse", 32'(n_valid + n_fail), 32'd0);
    seed_load[0] = 1'b1;
    seed_in[0] = 16'h0;
    @(negedge clk);
    seed_load[0] = 1'b0;
    checkOutput("seed_zero_loads_one", 32'(dut.lfsr_q), 32'd1);
    applyStimulus(0, 64'h0, 20);

    // Small grid, back-to-back requests, random boards with one free cell.
    occ_map[1] = 64'h0;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      occ = {32'($urandom), 32'($urandom)};
      if (i % 3 == 0) occ = occ | {32'($urandom), 32'($urandom)};
      occ[$urandom_range(0, 5)*8 + $urandom_range(0, 4)] = 1'b0;
      applyStimulus(1, occ, 300);
      checkOutput("small_x_range", 32'(int'(x_out[1]) < 5), 32'd1);
      checkOutput("small_y_range", 32'(int'(y_out[1]) < 6), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/food_spawner.md
FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 SHALL have parameters (name, default, meaning): LFSR_W, 16, LFSR width.
REQ-002 SHALL have parameter TAPS, 16'hB400, Galois feedback mask (right-shift form).
REQ-003 SHALL have parameter SEED, 16'hACE1, LFSR reset value; a zero SEED loads 1 instead.
REQ-004 SHALL have parameter COORD_W, 3, coordinate width; 2*COORD_W <= LFSR_W.
REQ-005 SHALL have parameters GRID_W, 8 and GRID_H, 8: legal x range 0..GRID_W-1 and legal y range 0..GRID_H-1, each <= 2**COORD_W.
REQ-006 SHALL have parameter MAX_TRIES, 15, random draws allowed before raster fallback.
REQ-007 SHALL have parameters RST_X, 3 and RST_Y, 1: reset values of x_out and y_out.
REQ-008 Ports (name, direction, width, meaning): clk, in, 1, the single clock, all state on rising edge.
REQ-009 reset, in, 1, asynchronous active-high reset.
REQ-010 req, in, 1, spawn request.
REQ-011 seed_load, in, 1 and seed_in, in, LFSR_W: reseed the LFSR.
REQ-012 probe_x, out, COORD_W and probe_y, out, COORD_W: cell being queried.
REQ-013 occupied, in, 1, combinational answer for the current probe; 1 = snake on cell.
REQ-014 x_out, out, COORD_W and y_out, out, COORD_W: last food position.
REQ-015 valid, out, 1, one-cycle pulse when x_out/y_out are updated.
REQ-016 fail, out, 1, one-cycle pulse when no free cell exists.
REQ-017 busy, out, 1, high while a request is in progress.

Function
REQ-018 LFSR SHALL step every cycle, including while idle: lfsr = (lfsr>>1) ^ (lsb ? TAPS : 0).
REQ-019 seed_load SHALL override stepping that cycle; seed_in==0 SHALL load 1.
REQ-020 Candidate SHALL be x = lfsr[COORD_W-1:0], y = lfsr[2*COORD_W-1:COORD_W], sampled in DRAW.
REQ-021 FSM states SHALL be IDLE, DRAW, CHECK, SCAN.
REQ-022 IDLE: req=1 SHALL go to DRAW with busy=1 and tries=0; a req while busy SHALL be ignored, not queued.
REQ-023 DRAW: an out-of-range candidate (x>=GRID_W or y>=GRID_H) SHALL increment tries and stay in DRAW.
REQ-024 DRAW: an in-range candidate SHALL be registered to probe_x/probe_y, then go to CHECK.
REQ-025 CHECK: occupied=0 SHALL copy the probe to x_out/y_out, pulse valid and go to IDLE with busy=0.
REQ-026 CHECK: occupied=1 SHALL increment tries and return to DRAW.
REQ-027 When tries reaches MAX_TRIES, the FSM SHALL go to SCAN instead of DRAW, with probe set to (0,0).
REQ-028 SCAN SHALL test one cell per cycle in raster order (x fastest, then y) over the legal grid only.
REQ-029 SCAN: the first cell with occupied=0 SHALL be output as in REQ-025.
REQ-030 SCAN: if cell (GRID_W-1, GRID_H-1) is occupied, the FSM SHALL pulse fail, leave x_out/y_out unchanged and go to IDLE.
REQ-031 Minimum latency SHALL be 3 cycles: req sampled at edge N, valid high after edge N+3.
REQ-032 A new req SHALL be accepted in the same cycle valid or fail is high, because the FSM is already IDLE.
REQ-033 valid and fail SHALL never be high together; x_out SHALL never be >= GRID_W and y_out SHALL never be >= GRID_H.

Reset
REQ-034 Reset SHALL force: FSM=IDLE, lfsr=SEED, tries=0, probe=(0,0), x_out=RST_X, y_out=RST_Y, valid=fail=busy=0.
REQ-035 Reset asserted mid-operation, including in SCAN, SHALL abort the request with no valid or fail pulse.

Verification
REQ-036 Reset, defaults -> x_out=3, y_out=1, busy=0; lfsr=0xACE1, and 0xE270 after the first edge.
REQ-037 Defaults, occupied tied 0, single req -> valid exactly 3 cycles later; x_out/y_out match the bench LFSR model bits at DRAW.
REQ-038 occupied=1 except at probe (5,2) -> a valid pulse with (5,2) returned, either by draw or by scan, never an occupied cell.
REQ-039 occupied tied 1 -> MAX_TRIES draws, then 64 SCAN cycles, then one fail pulse, no valid pulse, and x_out/y_out unchanged.
REQ-040 GRID_W=5, GRID_H=6, 1000 back-to-back reqs -> all x_out<5 and y_out<6; every req ends in exactly one valid.
REQ-041 Reset pulse during SCAN, and seed_load with seed_in=0 -> REQ-034 values follow, and the LFSR holds 1 after the load.
